// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU opcodes and the mul/div FSM encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32 shift-add or restoring
// iterations on operand magnitudes, sign fix-up and special-case override on the last one.
module ex_muldiv
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [4:0]      i_ALUOp,
  input  logic [XLEN-1:0] i_RD1,
  input  logic [XLEN-1:0] i_RD2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic        w_accept;
  logic        w_busy;
  logic        w_last;

  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic [31:0] r_dividend;
  logic        r_neg;
  logic        r_dz;
  logic        r_ovf;
  logic [5:0]  r_count;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;
  logic        r_done;

  logic        w_sign_a;
  logic        w_sign_b;
  logic        w_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_div_hi;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_div_nxt;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept qualification and stall request.
  // DONE may accept directly: the pipeline advances out of DONE, so a new op can start at that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        w_accept = i_start && is_m_op(i_ALUOp) && !i_flush;
        w_busy   = w_accept;
        if (w_accept) begin
          w_state_nxt = MD_CALC;
        end else begin
          w_state_nxt = MD_IDLE;
        end
      end
      MD_CALC: begin
        w_busy = 1'b1;
        if (i_flush) begin
          w_state_nxt = MD_IDLE;
        end else if (r_count == 6'd31) begin
          w_last      = 1'b1;
          w_state_nxt = MD_DONE;
        end else begin
          w_state_nxt = MD_CALC;
        end
      end
      MD_DONE: begin
        w_accept = i_start && is_m_op(i_ALUOp) && !i_flush;
        if (w_accept) begin
          w_state_nxt = MD_CALC;
        end else begin
          w_state_nxt = MD_IDLE;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  // Operand signs, magnitudes and final-negate flag for the incoming operation
  always_comb begin
    w_sign_a = 1'b0;
    w_sign_b = 1'b0;
    w_neg    = 1'b0;
    case (i_ALUOp)
      ALU_MULH, ALU_DIV, ALU_REM: begin
        w_sign_a = i_RD1[31];
        w_sign_b = i_RD2[31];
      end
      ALU_MULHSU: begin
        w_sign_a = i_RD1[31];
      end
      default: begin
        w_sign_a = 1'b0;
      end
    endcase
    case (i_ALUOp)
      ALU_MULH, ALU_DIV:   w_neg = w_sign_a ^ w_sign_b;
      ALU_MULHSU, ALU_REM: w_neg = w_sign_a;
      default:             w_neg = 1'b0;
    endcase
    if (w_sign_a) begin
      w_mag_a = 32'd0 - i_RD1;
    end else begin
      w_mag_a = i_RD1;
    end
    if (w_sign_b) begin
      w_mag_b = 32'd0 - i_RD2;
    end else begin
      w_mag_b = i_RD2;
    end
  end

  // One iteration step plus the sign fix-up and special-case result for the last step
  always_comb begin
    w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    w_mul_nxt = {w_mul_sum, r_acc[31:1]};
    w_div_hi  = r_acc[63:31];
    w_div_ge  = (w_div_hi >= {1'b0, r_opb});
    w_div_sub = w_div_hi[31:0] - r_opb;
    if (w_div_ge) begin
      w_div_nxt = {w_div_sub, r_acc[30:0], 1'b1};
    end else begin
      w_div_nxt = {r_acc[62:0], 1'b0};
    end
    if (r_op[2]) begin
      w_acc_nxt = w_div_nxt;
    end else begin
      w_acc_nxt = w_mul_nxt;
    end
    if (r_neg) begin
      w_prod = 64'd0 - w_acc_nxt;
      w_quo  = 32'd0 - w_acc_nxt[31:0];
      w_rem  = 32'd0 - w_acc_nxt[63:32];
    end else begin
      w_prod = w_acc_nxt;
      w_quo  = w_acc_nxt[31:0];
      w_rem  = w_acc_nxt[63:32];
    end
    case ({2'b10, r_op})
      ALU_MUL: w_final = w_prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: w_final = w_prod[63:32];
      ALU_DIV, ALU_DIVU: begin
        if (r_dz) begin
          w_final = 32'hFFFF_FFFF;
        end else if (r_ovf) begin
          w_final = 32'h8000_0000;
        end else begin
          w_final = w_quo;
        end
      end
      ALU_REM, ALU_REMU: begin
        if (r_dz) begin
          w_final = r_dividend;
        end else if (r_ovf) begin
          w_final = 32'd0;
        end else begin
          w_final = w_rem;
        end
      end
      default: w_final = 32'd0;
    endcase
  end

  // Datapath registers: operand capture on accept, iterate in CALC, result capture on last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_acc      <= 64'd0;
      r_opb      <= 32'd0;
      r_dividend <= 32'd0;
      r_neg      <= 1'b0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_count    <= 6'd0;
      r_result   <= 32'd0;
      r_rd_out   <= 5'd0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= i_ALUOp[2:0];
        r_rd       <= i_rd;
        r_dividend <= i_RD1;
        r_neg      <= w_neg;
        r_dz       <= (i_RD2 == 32'd0);
        r_ovf      <= (i_RD1 == 32'h8000_0000) && (i_RD2 == 32'hFFFF_FFFF) &&
                      ((i_ALUOp == ALU_DIV) || (i_ALUOp == ALU_REM));
        r_count    <= 6'd0;
        if (i_ALUOp[2]) begin
          r_acc <= {32'd0, w_mag_a};
          r_opb <= w_mag_b;
        end else begin
          r_acc <= {32'd0, w_mag_b};
          r_opb <= w_mag_a;
        end
      end else if (r_state == MD_CALC) begin
        r_acc   <= w_acc_nxt;
        r_count <= r_count + 6'd1;
      end
      if (w_last) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end
      r_done <= w_last;
    end
  end

  assign o_busy   = w_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_rd     = r_rd_out;

endmodule
